shift_readout_ctrl: RTL and testbench

- Sequencer directly downstream of the parallel-load word shifter.
- Loads the shifter via a set pulse, then samples the shifter's word-0 output.
- Presents each word on a valid/ready stream, then pulses shift to advance to the next word.
- Unloads exactly LENGTH words per start; sits between the shifter and the row-output/serial-link stage.

---
 rtl/shift_readout_ctrl.sv | 110 +++++++++++
 tb/tb_shift_readout_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_readout_ctrl.sv
// shift_readout_ctrl: loads a word shifter, then streams LENGTH words out over valid/ready.
// Optional out_index port (word number of out_data) when SHIFT_READOUT_INDEX_EN is defined.
module shift_readout_ctrl #(
  parameter int BITS = 4,
  parameter int LENGTH = 4,
  localparam int CNT_W = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            overrun_clr,
  input  logic [BITS-1:0] sh_data,
  output logic            sh_set,
  output logic            sh_shift,
  output logic [BITS-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            busy,
  output logic            done,
  output logic            overrun
`ifdef SHIFT_READOUT_INDEX_EN
  ,
  output logic [CNT_W-1:0] out_index
`endif
);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CAPTURE, PRESENT, SHIFT} state_e;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LENGTH - 1);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BITS-1:0]   data_q, data_d;
  logic              set_q, set_d, shift_q, shift_d, valid_q, valid_d;
  logic              last_q, last_d, done_q, done_d, ovr_q, ovr_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    set_d   = 1'b0;
    shift_d = 1'b0;
    done_d  = 1'b0;
    // a start arriving outside IDLE is dropped and flagged; setting beats clearing
    ovr_d   = (start && state_q != IDLE) || (ovr_q && !overrun_clr);
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        cnt_d   = '0;
        set_d   = 1'b1;
      end
      LOAD:    state_d = SETTLE;
      SETTLE:  state_d = CAPTURE;
      CAPTURE: begin
        data_d  = sh_data;
        valid_d = 1'b1;
        last_d  = cnt_q == LAST;
        state_d = PRESENT;
      end
      PRESENT: if (out_ready) begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        state_d = last_q ? IDLE : SHIFT;
        done_d  = last_q;
        shift_d = !last_q;
        cnt_d   = last_q ? cnt_q : cnt_q + 1'b1;
      end
      SHIFT:   state_d = SETTLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      set_q   <= 1'b0;
      shift_q <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      set_q   <= set_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end
`ifdef SHIFT_READOUT_INDEX_EN
  logic [CNT_W-1:0] idx_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) idx_q <= '0;
    else if (state_q == CAPTURE) idx_q <= cnt_q;
  end
  assign out_index = idx_q;
`endif
  assign sh_set    = set_q;
  assign sh_shift  = shift_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign overrun   = ovr_q;
endmodule

// File: tb/tb_shift_readout_ctrl.sv
// tb_shift_readout_ctrl: directed vectors for the shifter readout sequencer (LENGTH 4 and LENGTH 1).
module tb_shift_readout_ctrl;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, overrun_clr = 1'b0, out_ready = 1'b0;
  logic [3:0] sh_data, out_data;
  logic sh_set, sh_shift, out_valid, out_last, busy, done, overrun;
  logic start2 = 1'b0, ready2 = 1'b0;
  logic [3:0] data2;
  logic set2, shift2, valid2, last2, busy2, done2, ovr2;
  int total = 0, bad = 0, n_set = 0, n_shift = 0, n_shift2 = 0, n_both = 0;
  logic [3:0] sh_mem [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
`ifdef SHIFT_READOUT_INDEX_EN
  logic [1:0] out_index;
  logic [0:0] idx2;
`endif
  always #5 clk = ~clk;
  shift_readout_ctrl #(.BITS(4), .LENGTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .overrun_clr(overrun_clr), .sh_data(sh_data),
    .sh_set(sh_set), .sh_shift(sh_shift), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done), .overrun(overrun)
`ifdef SHIFT_READOUT_INDEX_EN
    , .out_index(out_index)
`endif
  );
  shift_readout_ctrl #(.BITS(4), .LENGTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start2), .overrun_clr(1'b0), .sh_data(4'h9),
    .sh_set(set2), .sh_shift(shift2), .out_data(data2), .out_valid(valid2),
    .out_ready(ready2), .out_last(last2), .busy(busy2), .done(done2), .overrun(ovr2)
`ifdef SHIFT_READOUT_INDEX_EN
    , .out_index(idx2)
`endif
  );
  // upstream shifter model: load 3,5,A,C on set, move toward word 0 on shift
  always @(posedge clk) begin
    if (sh_set) sh_mem <= '{4'h3, 4'h5, 4'hA, 4'hC};
    else if (sh_shift) sh_mem <= '{sh_mem[1], sh_mem[2], sh_mem[3], 4'h0};
    if (sh_set) n_set++;
    if (sh_shift) n_shift++;
    if (sh_set && sh_shift) n_both++;
    if (shift2) n_shift2++;
  end
  assign sh_data = sh_mem[0];
  typedef struct {
    logic rdy, set, shf, vld, lst, dn, bsy;
    logic [3:0] dat;
  } vec_t;
  vec_t tv [18];
  function automatic vec_t mk(logic set, logic shf, logic vld, logic lst, logic dn, logic bsy, logic [3:0] dat);
    mk = '{rdy: 1'b1, set: set, shf: shf, vld: vld, lst: lst, dn: dn, bsy: bsy, dat: dat};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start_row();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("valid_timeout", out_valid, 1);
  endtask
  task automatic word(input logic [3:0] exp, input logic lst, input int idx);
    wait_valid();
    chk("word_data", out_data, exp);
    chk("word_last", out_last, lst);
`ifdef SHIFT_READOUT_INDEX_EN
    chk("word_index", out_index, idx);
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_valid", out_valid, 0);
    chk("hs_shift", sh_shift, !lst);
    chk("hs_done", done, lst);
  endtask
  task automatic check_zero(input string nm);
    chk({nm, "_set"}, sh_set, 0);
    chk({nm, "_shift"}, sh_shift, 0);
    chk({nm, "_data"}, out_data, 0);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_last"}, out_last, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_ovr"}, overrun, 0);
  endtask
  initial begin
    int base_set, base_shift;
    tv[0]  = mk(1, 0, 0, 0, 0, 1, 4'h0);
    tv[1]  = mk(0, 0, 0, 0, 0, 1, 4'h0);
    tv[2]  = mk(0, 0, 0, 0, 0, 1, 4'h0);
    tv[3]  = mk(0, 0, 1, 0, 0, 1, 4'h3);
    tv[4]  = mk(0, 1, 0, 0, 0, 1, 4'h3);
    tv[5]  = mk(0, 0, 0, 0, 0, 1, 4'h3);
    tv[6]  = mk(0, 0, 0, 0, 0, 1, 4'h3);
    tv[7]  = mk(0, 0, 1, 0, 0, 1, 4'h5);
    tv[8]  = mk(0, 1, 0, 0, 0, 1, 4'h5);
    tv[9]  = mk(0, 0, 0, 0, 0, 1, 4'h5);
    tv[10] = mk(0, 0, 0, 0, 0, 1, 4'h5);
    tv[11] = mk(0, 0, 1, 0, 0, 1, 4'hA);
    tv[12] = mk(0, 1, 0, 0, 0, 1, 4'hA);
    tv[13] = mk(0, 0, 0, 0, 0, 1, 4'hA);
    tv[14] = mk(0, 0, 0, 0, 0, 1, 4'hA);
    tv[15] = mk(0, 0, 1, 1, 0, 1, 4'hC);
    tv[16] = mk(0, 0, 0, 0, 1, 0, 4'hC);
    tv[17] = mk(0, 0, 0, 0, 0, 0, 4'hC);
    repeat (2) tick();
    check_zero("reset");
    reset = 1'b0;
    tick();
    // streaming run with out_ready held high
    base_set = n_set;
    base_shift = n_shift;
    start = 1'b1;
    for (int k = 0; k < 18; k++) begin
      out_ready = tv[k].rdy;
      tick();
      start = 1'b0;
      chk($sformatf("e%0d_set", k), sh_set, tv[k].set);
      chk($sformatf("e%0d_shift", k), sh_shift, tv[k].shf);
      chk($sformatf("e%0d_valid", k), out_valid, tv[k].vld);
      chk($sformatf("e%0d_last", k), out_last, tv[k].lst);
      chk($sformatf("e%0d_done", k), done, tv[k].dn);
      chk($sformatf("e%0d_busy", k), busy, tv[k].bsy);
      chk($sformatf("e%0d_data", k), out_data, tv[k].dat);
    end
    out_ready = 1'b0;
    chk("run_sets", n_set - base_set, 1);
    chk("run_shifts", n_shift - base_shift, 3);
    // consumer stalls five cycles on word 2
    base_shift = n_shift;
    start_row();
    word(4'h3, 0, 0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_data", out_data, 4'h5);
      chk("stall_valid", out_valid, 1);
      chk("stall_shift", sh_shift, 0);
    end
    chk("stall_shift_cnt", n_shift - base_shift, 1);
    word(4'h5, 0, 1);
    word(4'hA, 0, 2);
    word(4'hC, 1, 3);
    // start while presenting word 1 raises overrun, row still completes
    start_row();
    wait_valid();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ovr_set", overrun, 1);
    chk("ovr_hold_valid", out_valid, 1);
    word(4'h3, 0, 0);
    word(4'h5, 0, 1);
    word(4'hA, 0, 2);
    word(4'hC, 1, 3);
    chk("ovr_sticky", overrun, 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovr_clr", overrun, 0);
    // clear and new overrun on the same edge: set wins; start on final handshake is ignored
    start_row();
    wait_valid();
    start = 1'b1;
    overrun_clr = 1'b1;
    tick();
    start = 1'b0;
    overrun_clr = 1'b0;
    chk("ovr_set_wins", overrun, 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovr_clr2", overrun, 0);
    word(4'h3, 0, 0);
    word(4'h5, 0, 1);
    word(4'hA, 0, 2);
    wait_valid();
    base_set = n_set;
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    chk("final_hs_done", done, 1);
    chk("final_hs_ovr", overrun, 1);
    chk("final_hs_busy", busy, 0);
    tick();
    chk("final_hs_noset", sh_set, 0);
    chk("final_hs_idle", busy, 0);
    chk("final_hs_sets", n_set - base_set, 0);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    // asynchronous reset in SETTLE of word 2
    start_row();
    word(4'h3, 0, 0);
    tick();
    chk("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    tick();
    reset = 1'b0;
    tick();
    chk("no_stale_done", done, 0);
    start_row();
    word(4'h3, 0, 0);
    word(4'h5, 0, 1);
    word(4'hA, 0, 2);
    word(4'hC, 1, 3);
    tick();
    chk("after_done", done, 0);
    // LENGTH = 1 instance
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int n = 0; n < 10 && !valid2; n++) tick();
    chk("l1_valid", valid2, 1);
    chk("l1_data", data2, 4'h9);
    chk("l1_last", last2, 1);
    ready2 = 1'b1;
    tick();
    ready2 = 1'b0;
    chk("l1_done", done2, 1);
    chk("l1_valid_lo", valid2, 0);
    chk("l1_busy", busy2, 0);
    tick();
    chk("l1_done_lo", done2, 0);
    chk("l1_shifts", n_shift2, 0);
    chk("set_shift_overlap", n_both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
